// File: rtl/ddr3_lane_pkg.sv
// Shared types and encodings for the DDR3 DM lane write-path formatter.
// Holds the tap FSM state enum, the latency-pipeline beat type and the OE/DM constants.
package ddr3_lane_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_MOVE,
    ST_SETTLE,
    ST_LOAD,
    ST_ACK
  } tap_state_t;

  typedef struct packed {
    logic       en;
    logic [7:0] mask;
  } wr_beat_t;

  localparam logic [7:0] IDLE_MASK  = 8'hFF;
  localparam logic [3:0] OE_PRE     = 4'b1000;
  localparam logic [3:0] OE_POST    = 4'b0001;
  localparam logic [3:0] OE_FULL    = 4'b1111;
  localparam int         SETTLE_CYC = 2;

  // Overlapping burst/preamble/postamble windows simply OR together.
  function automatic logic [3:0] oe_merge(input logic burst, input logic pre, input logic post);
    logic [3:0] v;
    v = 4'b0000;
    if (burst) v = v | OE_FULL;
    if (pre)   v = v | OE_PRE;
    if (post)  v = v | OE_POST;
    return v;
  endfunction

endpackage

// File: rtl/ddr3_dl_tap_ctrl.sv
// Delay-line tap sequencer: single-step and reload transactions, tap counter,
// and the sticky out-of-range flag.
module ddr3_dl_tap_ctrl
  import ddr3_lane_pkg::*;
#(
  parameter int TAP_W = 7
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req,
  input  logic             i_dir,
  input  logic             i_load_req,
  input  logic             i_oor_in,
  output logic             o_ack,
  output logic [TAP_W-1:0] o_tap,
  output logic             o_oor,
  output logic             o_move,
  output logic             o_dir,
  output logic             o_load
);

  localparam logic [1:0] LP_SETTLE_LAST = 2'(SETTLE_CYC - 1);

  tap_state_t       r_state;
  tap_state_t       w_state_nxt;
  logic [1:0]       r_settle_cnt;
  logic [TAP_W-1:0] r_tap;
  logic             r_oor;
  logic             r_ack;
  logic             r_move;
  logic             r_dir;
  logic             r_load;
  logic             w_sat;
  logic             w_step;

  function automatic logic tap_at_limit(input logic [TAP_W-1:0] tap, input logic dir);
    return dir ? (tap == {TAP_W{1'b1}}) : (tap == {TAP_W{1'b0}});
  endfunction

  assign w_sat  = tap_at_limit(r_tap, r_dir);
  assign w_step = (r_state == ST_SETUP) && !w_sat;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (i_load_req)  w_state_nxt = ST_LOAD;
        else if (i_req)  w_state_nxt = ST_SETUP;
      end
      ST_SETUP:  w_state_nxt = ST_MOVE;
      ST_MOVE:   w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (r_settle_cnt == LP_SETTLE_LAST) w_state_nxt = ST_ACK;
      ST_LOAD:   w_state_nxt = ST_ACK;
      ST_ACK:    w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Pulses and tap updates are registered on entry to their state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= 2'd0;
      r_tap        <= '0;
      r_oor        <= 1'b0;
      r_ack        <= 1'b0;
      r_move       <= 1'b0;
      r_dir        <= 1'b0;
      r_load       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= (r_state == ST_SETTLE) ? r_settle_cnt + 2'd1 : 2'd0;
      r_ack        <= (w_state_nxt == ST_ACK);
      r_load       <= (w_state_nxt == ST_LOAD);
      r_move       <= w_step;
      if (r_state == ST_IDLE && w_state_nxt == ST_SETUP) r_dir <= i_dir;
      if (w_step)
        r_tap <= r_dir ? r_tap + TAP_W'(1) : r_tap - TAP_W'(1);
      else if (w_state_nxt == ST_LOAD)
        r_tap <= '0;
      r_oor <= ((w_state_nxt == ST_LOAD) ? 1'b0 : r_oor) | i_oor_in |
               ((r_state == ST_SETUP) && w_sat);
    end
  end

  assign o_ack  = r_ack;
  assign o_tap  = r_tap;
  assign o_oor  = r_oor;
  assign o_move = r_move;
  assign o_dir  = r_dir;
  assign o_load = r_load;

endmodule

// File: rtl/ddr3_lane_dm_tx_fmt.sv
// DDR3 DM lane write-path formatter: write-latency pipeline, OE pre/postamble, training
// override, ODT gating (macro DDR3_DM_ODT_CTRL_EN) and the delay-line tap controller.
module ddr3_lane_dm_tx_fmt
  import ddr3_lane_pkg::*;
#(
  parameter int WL_MAX = 16,
  parameter int TAP_W  = 7
) (
  input  logic             FAB_CLK,
  input  logic             SYNC_RST_N,
  input  logic [3:0]       WL_CFG,
  input  logic             WR_EN,
  input  logic [7:0]       WR_MASK,
  input  logic             TRAIN_EN,
  input  logic [7:0]       TRAIN_PATTERN,
  input  logic             RD_ODT_REQ,
  input  logic             DL_REQ,
  input  logic             DL_DIR,
  input  logic             DL_LOAD_REQ,
  output logic             DL_ACK,
  output logic [TAP_W-1:0] DL_TAP,
  output logic             DL_OOR,
  input  logic             DELAY_LINE_OUT_OF_RANGE_0,
  output logic             DELAY_LINE_MOVE_0,
  output logic             DELAY_LINE_DIRECTION_0,
  output logic             DELAY_LINE_LOAD_0,
  output logic [7:0]       TX_DATA_0,
  output logic [3:0]       OE_DATA_0,
  output logic             ODT_EN_0
);

  wr_beat_t   r_pipe [WL_MAX];
  wr_beat_t   w_hist [WL_MAX+1];
  logic [3:0] r_wl;
  logic [3:0] w_wl_cfg;
  logic [7:0] r_tx;
  logic [3:0] r_oe;
  logic       w_pipe_busy;
  logic       w_burst;
  logic       w_pre;
  logic       w_post;
  logic [7:0] w_mask;
  logic [3:0] w_oe_nxt;
  logic [7:0] w_tx_nxt;

  assign w_wl_cfg = (WL_CFG == 4'd0) ? 4'd1 : WL_CFG;

  // w_hist[j] is the request from j cycles ago; index 0 is the live input.
  always_comb begin
    w_hist[0] = '{en: WR_EN, mask: WR_MASK};
    for (int k = 0; k < WL_MAX; k++) w_hist[k+1] = r_pipe[k];
  end

  always_comb begin
    w_pipe_busy = WR_EN;
    for (int k = 0; k < WL_MAX; k++) w_pipe_busy = w_pipe_busy | r_pipe[k].en;
  end

  // Outputs are registered, so the value formed now appears next cycle. With latency 1 a
  // preamble would need the request before it arrives, so none is produced.
  always_comb begin
    w_burst = 1'b0;
    w_pre   = 1'b0;
    w_post  = 1'b0;
    w_mask  = IDLE_MASK;
    for (int k = 0; k <= WL_MAX; k++) begin
      if (k == int'(r_wl) - 1 && w_hist[k].en) begin
        w_burst = 1'b1;
        w_mask  = w_hist[k].mask;
      end
      if (k == int'(r_wl) - 2 && w_hist[k].en) w_pre  = 1'b1;
      if (k == int'(r_wl)     && w_hist[k].en) w_post = 1'b1;
    end
  end

  assign w_oe_nxt = TRAIN_EN ? OE_FULL       : oe_merge(w_burst, w_pre, w_post);
  assign w_tx_nxt = TRAIN_EN ? TRAIN_PATTERN : w_mask;

  // Latency changes only when nothing is in flight, so no burst sees two latencies.
  always_ff @(posedge FAB_CLK) begin
    if (!SYNC_RST_N) begin
      for (int k = 0; k < WL_MAX; k++) r_pipe[k] <= '0;
      r_wl <= 4'd1;
      r_tx <= IDLE_MASK;
      r_oe <= 4'b0000;
    end else begin
      r_pipe[0] <= '{en: WR_EN, mask: WR_MASK};
      for (int k = 1; k < WL_MAX; k++) r_pipe[k] <= r_pipe[k-1];
      if (!w_pipe_busy && r_oe == 4'b0000) r_wl <= w_wl_cfg;
      r_tx <= w_tx_nxt;
      r_oe <= w_oe_nxt;
    end
  end

  assign TX_DATA_0 = r_tx;
  assign OE_DATA_0 = r_oe;

`ifdef DDR3_DM_ODT_CTRL_EN
  logic r_odt;

  // Termination is dropped for any cycle in which the DM driver is enabled.
  always_ff @(posedge FAB_CLK) begin
    if (!SYNC_RST_N) r_odt <= 1'b0;
    else             r_odt <= RD_ODT_REQ & ~(|w_oe_nxt);
  end

  assign ODT_EN_0 = r_odt;
`else
  logic w_unused_odt;

  assign w_unused_odt = RD_ODT_REQ;
  assign ODT_EN_0     = 1'b0;
`endif

  ddr3_dl_tap_ctrl #(
    .TAP_W(TAP_W)
  ) u_tap_ctrl (
    .i_clk      (FAB_CLK),
    .i_rst_n    (SYNC_RST_N),
    .i_req      (DL_REQ),
    .i_dir      (DL_DIR),
    .i_load_req (DL_LOAD_REQ),
    .i_oor_in   (DELAY_LINE_OUT_OF_RANGE_0),
    .o_ack      (DL_ACK),
    .o_tap      (DL_TAP),
    .o_oor      (DL_OOR),
    .o_move     (DELAY_LINE_MOVE_0),
    .o_dir      (DELAY_LINE_DIRECTION_0),
    .o_load     (DELAY_LINE_LOAD_0)
  );

endmodule

// File: tb/tb_ddr3_lane_dm_tx_fmt.sv
// Directed bench for ddr3_lane_dm_tx_fmt: latency pipeline, OE shaping, training, ODT,
// tap sequencing and reset abort. ODT expectations follow DDR3_DM_ODT_CTRL_EN.
module tb_ddr3_lane_dm_tx_fmt;

`ifdef DDR3_DM_ODT_CTRL_EN
  localparam logic ODT_ON = 1'b1;
`else
  localparam logic ODT_ON = 1'b0;
`endif

  logic       FAB_CLK = 1'b0;
  logic       SYNC_RST_N;
  logic [3:0] WL_CFG;
  logic       WR_EN;
  logic [7:0] WR_MASK;
  logic       TRAIN_EN;
  logic [7:0] TRAIN_PATTERN;
  logic       RD_ODT_REQ;
  logic       DL_REQ;
  logic       DL_DIR;
  logic       DL_LOAD_REQ;
  logic       DL_ACK;
  logic [6:0] DL_TAP;
  logic       DL_OOR;
  logic       DELAY_LINE_OUT_OF_RANGE_0;
  logic       DELAY_LINE_MOVE_0;
  logic       DELAY_LINE_DIRECTION_0;
  logic       DELAY_LINE_LOAD_0;
  logic [7:0] TX_DATA_0;
  logic [3:0] OE_DATA_0;
  logic       ODT_EN_0;

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_oe;
  logic [7:0] exp_tx;
  logic [6:0] exp_tap;

  always #5 FAB_CLK = ~FAB_CLK;

  ddr3_lane_dm_tx_fmt dut (
    .FAB_CLK                   (FAB_CLK),
    .SYNC_RST_N                (SYNC_RST_N),
    .WL_CFG                    (WL_CFG),
    .WR_EN                     (WR_EN),
    .WR_MASK                   (WR_MASK),
    .TRAIN_EN                  (TRAIN_EN),
    .TRAIN_PATTERN             (TRAIN_PATTERN),
    .RD_ODT_REQ                (RD_ODT_REQ),
    .DL_REQ                    (DL_REQ),
    .DL_DIR                    (DL_DIR),
    .DL_LOAD_REQ               (DL_LOAD_REQ),
    .DL_ACK                    (DL_ACK),
    .DL_TAP                    (DL_TAP),
    .DL_OOR                    (DL_OOR),
    .DELAY_LINE_OUT_OF_RANGE_0 (DELAY_LINE_OUT_OF_RANGE_0),
    .DELAY_LINE_MOVE_0         (DELAY_LINE_MOVE_0),
    .DELAY_LINE_DIRECTION_0    (DELAY_LINE_DIRECTION_0),
    .DELAY_LINE_LOAD_0         (DELAY_LINE_LOAD_0),
    .TX_DATA_0                 (TX_DATA_0),
    .OE_DATA_0                 (OE_DATA_0),
    .ODT_EN_0                  (ODT_EN_0)
  );

  task automatic tick();
    @(posedge FAB_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] eoe, input logic [7:0] etx);
    chk({tag, "_oe"}, 32'(OE_DATA_0), 32'(eoe));
    chk({tag, "_tx"}, 32'(TX_DATA_0), 32'(etx));
  endtask

  task automatic drain();
    repeat (20) tick();
  endtask

  task automatic do_load();
    DL_LOAD_REQ = 1'b1;
    tick();
    DL_LOAD_REQ = 1'b0;
    chk("load_pulse", 32'(DELAY_LINE_LOAD_0), 32'd1);
    chk("load_tap", 32'(DL_TAP), 32'd0);
    chk("load_oor", 32'(DL_OOR), 32'd0);
    tick();
    chk("load_ack", 32'(DL_ACK), 32'd1);
    chk("load_pulse_end", 32'(DELAY_LINE_LOAD_0), 32'd0);
    tick();
    chk("load_ack_end", 32'(DL_ACK), 32'd0);
  endtask

  task automatic do_step(input logic dir, input logic exp_move, input logic [6:0] etap);
    DL_REQ = 1'b1;
    DL_DIR = dir;
    tick();
    DL_REQ = 1'b0;
    chk("step_setup_dir", 32'(DELAY_LINE_DIRECTION_0), 32'(dir));
    chk("step_setup_move", 32'(DELAY_LINE_MOVE_0), 32'd0);
    tick();
    chk("step_move", 32'(DELAY_LINE_MOVE_0), 32'(exp_move));
    repeat (3) tick();
    chk("step_ack", 32'(DL_ACK), 32'd1);
    chk("step_tap", 32'(DL_TAP), 32'(etap));
    tick();
    chk("step_ack_end", 32'(DL_ACK), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    SYNC_RST_N = 1'b0;
    WL_CFG = 4'd1;
    WR_EN = 1'b0;
    WR_MASK = 8'h00;
    TRAIN_EN = 1'b0;
    TRAIN_PATTERN = 8'h00;
    RD_ODT_REQ = 1'b0;
    DL_REQ = 1'b0;
    DL_DIR = 1'b0;
    DL_LOAD_REQ = 1'b0;
    DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
    repeat (3) tick();

    chk_out("rst", 4'b0000, 8'hFF);
    chk("rst_odt", 32'(ODT_EN_0), 32'd0);
    chk("rst_tap", 32'(DL_TAP), 32'd0);
    chk("rst_oor", 32'(DL_OOR), 32'd0);
    chk("rst_ack", 32'(DL_ACK), 32'd0);
    chk("rst_move", 32'(DELAY_LINE_MOVE_0), 32'd0);
    chk("rst_load", 32'(DELAY_LINE_LOAD_0), 32'd0);
    SYNC_RST_N = 1'b1;
    tick();

    // Tap controller: reload, 128 increments with saturation on the last
    do_load();
    for (int s = 1; s <= 128; s++) begin
      exp_tap = (s <= 127) ? 7'(s) : 7'd127;
      do_step(1'b1, (s <= 127), exp_tap);
    end
    chk("sat_oor", 32'(DL_OOR), 32'd1);
    do_step(1'b0, 1'b1, 7'd126);
    chk("oor_sticky", 32'(DL_OOR), 32'd1);
    do_load();
    do_step(1'b0, 1'b0, 7'd0);
    chk("dec_at_zero_oor", 32'(DL_OOR), 32'd1);
    chk("dir_held", 32'(DELAY_LINE_DIRECTION_0), 32'd0);
    do_load();
    DELAY_LINE_OUT_OF_RANGE_0 = 1'b1;
    tick();
    DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
    chk("iod_range_oor", 32'(DL_OOR), 32'd1);

    // WL=5 single burst
    WL_CFG = 4'd5;
    tick();
    tick();
    WR_EN = 1'b1;
    WR_MASK = 8'h5A;
    tick();
    WR_EN = 1'b0;
    WR_MASK = 8'h00;
    for (int i = 1; i <= 7; i++) begin
      exp_oe = (i == 4) ? 4'b1000 : (i == 5) ? 4'b1111 : (i == 6) ? 4'b0001 : 4'b0000;
      exp_tx = (i == 5) ? 8'h5A : 8'hFF;
      chk_out("wl5", exp_oe, exp_tx);
      tick();
    end

    // WL=3, requests at B, B+1, B+3
    drain();
    WL_CFG = 4'd3;
    tick();
    tick();
    WR_EN = 1'b1;
    WR_MASK = 8'h11;
    tick();
    WR_MASK = 8'h22;
    tick();
    WR_EN = 1'b0;
    chk_out("b2b_c2", 4'b1000, 8'hFF);
    tick();
    WR_EN = 1'b1;
    WR_MASK = 8'h33;
    chk_out("b2b_c3", 4'b1111, 8'h11);
    tick();
    WR_EN = 1'b0;
    chk_out("b2b_c4", 4'b1111, 8'h22);
    tick();
    chk_out("b2b_c5", 4'b1001, 8'hFF);
    tick();
    chk_out("b2b_c6", 4'b1111, 8'h33);
    tick();
    chk_out("b2b_c7", 4'b0001, 8'hFF);
    tick();
    chk_out("b2b_c8", 4'b0000, 8'hFF);

    // Latency change with a burst in flight
    drain();
    WR_EN = 1'b1;
    WR_MASK = 8'hA5;
    tick();
    WR_EN = 1'b0;
    WL_CFG = 4'd7;
    chk_out("wlchg_c1", 4'b0000, 8'hFF);
    tick();
    chk_out("wlchg_c2", 4'b1000, 8'hFF);
    tick();
    chk_out("wlchg_c3", 4'b1111, 8'hA5);
    tick();
    chk_out("wlchg_c4", 4'b0001, 8'hFF);
    drain();
    WR_EN = 1'b1;
    WR_MASK = 8'h3C;
    tick();
    WR_EN = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      exp_oe = (i == 6) ? 4'b1000 : (i == 7) ? 4'b1111 : (i == 8) ? 4'b0001 : 4'b0000;
      exp_tx = (i == 7) ? 8'h3C : 8'hFF;
      chk_out("wl7", exp_oe, exp_tx);
      tick();
    end

    // ODT gating around a WL=2 burst
    drain();
    WL_CFG = 4'd2;
    tick();
    tick();
    RD_ODT_REQ = 1'b1;
    tick();
    tick();
    WR_EN = 1'b1;
    WR_MASK = 8'h0F;
    chk("odt_before", 32'(ODT_EN_0), 32'(ODT_ON));
    tick();
    WR_EN = 1'b0;
    chk_out("odt_pre", 4'b1000, 8'hFF);
    chk("odt_pre_odt", 32'(ODT_EN_0), 32'd0);
    tick();
    chk_out("odt_burst", 4'b1111, 8'h0F);
    chk("odt_burst_odt", 32'(ODT_EN_0), 32'd0);
    tick();
    chk_out("odt_post", 4'b0001, 8'hFF);
    chk("odt_post_odt", 32'(ODT_EN_0), 32'd0);
    tick();
    chk_out("odt_after", 4'b0000, 8'hFF);
    chk("odt_after_odt", 32'(ODT_EN_0), 32'(ODT_ON));

    // Training override
    TRAIN_EN = 1'b1;
    TRAIN_PATTERN = 8'hC3;
    tick();
    chk_out("train", 4'b1111, 8'hC3);
    chk("train_odt", 32'(ODT_EN_0), 32'd0);
    TRAIN_EN = 1'b0;
    tick();
    chk_out("train_exit", 4'b0000, 8'hFF);
    chk("train_exit_odt", 32'(ODT_EN_0), 32'(ODT_ON));
    RD_ODT_REQ = 1'b0;
    tick();
    chk("odt_req_low", 32'(ODT_EN_0), 32'd0);

    // WL_CFG=0 behaves as latency 1
    drain();
    WL_CFG = 4'd0;
    tick();
    tick();
    WR_EN = 1'b1;
    WR_MASK = 8'h81;
    chk_out("wl0_c0", 4'b0000, 8'hFF);
    tick();
    WR_EN = 1'b0;
    chk_out("wl0_c1", 4'b1111, 8'h81);
    tick();
    chk_out("wl0_c2", 4'b0001, 8'hFF);
    tick();
    chk_out("wl0_c3", 4'b0000, 8'hFF);

    // Reset during MOVE with a burst on the wire
    drain();
    DL_REQ = 1'b1;
    DL_DIR = 1'b1;
    tick();
    DL_REQ = 1'b0;
    WR_EN = 1'b1;
    WR_MASK = 8'h77;
    tick();
    WR_EN = 1'b0;
    chk("rstmv_move", 32'(DELAY_LINE_MOVE_0), 32'd1);
    chk("rstmv_tap", 32'(DL_TAP), 32'd1);
    chk("rstmv_dir", 32'(DELAY_LINE_DIRECTION_0), 32'd1);
    chk("rstmv_oor", 32'(DL_OOR), 32'd1);
    chk_out("rstmv_burst", 4'b1111, 8'h77);
    SYNC_RST_N = 1'b0;
    tick();
    chk_out("rstmv_after", 4'b0000, 8'hFF);
    chk("rstmv_after_move", 32'(DELAY_LINE_MOVE_0), 32'd0);
    chk("rstmv_after_dir", 32'(DELAY_LINE_DIRECTION_0), 32'd0);
    chk("rstmv_after_load", 32'(DELAY_LINE_LOAD_0), 32'd0);
    chk("rstmv_after_tap", 32'(DL_TAP), 32'd0);
    chk("rstmv_after_oor", 32'(DL_OOR), 32'd0);
    chk("rstmv_after_ack", 32'(DL_ACK), 32'd0);
    chk("rstmv_after_odt", 32'(ODT_EN_0), 32'd0);
    SYNC_RST_N = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstmv_idle_ack", 32'(DL_ACK), 32'd0);
      chk_out("rstmv_idle", 4'b0000, 8'hFF);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
